// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_STEP    = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic memwb_flush;
  } ctrl_t;

  // Whole front end holds and MEM/WB takes a bubble.
  localparam ctrl_t CTRL_FREEZE = '{
    pc_stall:    1'b1,
    ifid_stall:  1'b1,
    ifid_flush:  1'b0,
    idex_stall:  1'b1,
    idex_flush:  1'b0,
    exmem_stall: 1'b1,
    memwb_flush: 1'b1
  };

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and stage-register controls between the pipeline and the sequencer.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             dbg_halt;
  logic             dbg_step;

  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_stall;
  logic             idex_flush;
  logic             exmem_stall;
  logic             memwb_flush;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready, dbg_halt, dbg_step,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_flush, halted, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready, dbg_halt, dbg_step,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_flush, halted, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard terms and the prioritized stall/flush vector.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       memwait,
  output logic       loaduse,
  output logic       redirect_take,
  output ctrl_t      ctrl
);

  assign memwait = mem_req & ~mem_ready;

  assign loaduse = ex_mem_read & (ex_rd != REG_X0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) |
                    (id_use_rs2 & (id_rs2 == ex_rd)));

  // A held pipeline re-presents the redirect next cycle, so it only counts when not frozen.
  assign redirect_take = ex_redirect & ~memwait;

  always_comb begin
    ctrl = '0;
    if (memwait) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_redirect) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (loaduse) begin
      ctrl.pc_stall   = 1'b1;
      ctrl.ifid_stall = 1'b1;
      ctrl.idex_flush = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: debug/memory-wait FSM, freeze override and perf counters.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_RUN     | normal operation, hazard priority applies
//   ST_HALT    | debug freeze, all stages held every cycle
//   ST_STEP    | one cycle released from HALT with normal priority
//   ST_MEMWAIT | data memory stalled, waiting for mem_ready
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t             state_q, state_nxt;
  logic               ret_halt_q, ret_halt_nxt;
  logic [WAIT_W-1:0]  wait_q, wait_inc;
  logic               mem_err_q;
  logic [CNT_W-1:0]   stall_q, flush_q;

  logic   memwait, loaduse, redirect_take;
  ctrl_t  hz_ctrl, ctrl;
  logic   stall_inc, flush_inc;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .id_rs1        (bus.id_rs1),
    .id_rs2        (bus.id_rs2),
    .id_use_rs1    (bus.id_use_rs1),
    .id_use_rs2    (bus.id_use_rs2),
    .ex_rd         (bus.ex_rd),
    .ex_mem_read   (bus.ex_mem_read),
    .ex_redirect   (bus.ex_redirect),
    .mem_req       (bus.mem_req),
    .mem_ready     (bus.mem_ready),
    .memwait       (memwait),
    .loaduse       (loaduse),
    .redirect_take (redirect_take),
    .ctrl          (hz_ctrl)
  );

  always_comb begin
    state_nxt    = state_q;
    ret_halt_nxt = ret_halt_q;
    case (state_q)
      ST_RUN: begin
        if (memwait) begin
          state_nxt    = ST_MEMWAIT;
          ret_halt_nxt = 1'b0;
        end else if (bus.dbg_halt) begin
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (bus.dbg_step)      state_nxt = ST_STEP;
        else if (!bus.dbg_halt) state_nxt = ST_RUN;
      end
      ST_STEP: begin
        if (memwait) begin
          state_nxt    = ST_MEMWAIT;
          ret_halt_nxt = 1'b1;
        end else begin
          state_nxt = bus.dbg_halt ? ST_HALT : ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        if (!memwait) state_nxt = (ret_halt_q | bus.dbg_halt) ? ST_HALT : ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Outputs are Mealy; reset must silence them without waiting for an edge.
  always_comb begin
    ctrl = hz_ctrl;
    if (state_q == ST_HALT) ctrl = CTRL_FREEZE;
    if (rst)                ctrl = '0;
  end

  assign stall_inc = (state_q != ST_HALT) & ctrl.pc_stall;
  assign flush_inc = (state_q != ST_HALT) & redirect_take;
  assign wait_inc  = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      ret_halt_q <= 1'b0;
      wait_q     <= '0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_nxt;
      ret_halt_q <= ret_halt_nxt;
      if (state_q == ST_MEMWAIT) begin
        if (memwait) begin
          wait_q <= wait_inc;
          if (wait_inc == WAIT_MAX) mem_err_q <= 1'b1;
        end else begin
          wait_q <= '0;
        end
      end
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_stall    = ctrl.pc_stall;
  assign bus.ifid_stall  = ctrl.ifid_stall;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_stall  = ctrl.idex_stall;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_stall = ctrl.exmem_stall;
  assign bus.memwb_flush = ctrl.memwb_flush;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.mem_err     = mem_err_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard priority, mem wait/timeout, debug, reset, saturation.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_FREEZE = 7'b1101011;
  localparam logic [6:0] C_LU     = 7'b1100100;
  localparam logic [6:0] C_REDIR  = 7'b0010100;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus_a ();
  pipe_hazard_ctrl_if #(.CNT_W(3))  bus_b ();

  pipe_hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pipe_hazard_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic [6:0] ca;
  assign ca = {bus_a.pc_stall, bus_a.ifid_stall, bus_a.ifid_flush, bus_a.idex_stall,
               bus_a.idex_flush, bus_a.exmem_stall, bus_a.memwb_flush};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus_a.id_rs1 = 5'd0;  bus_a.id_rs2 = 5'd0;
    bus_a.id_use_rs1 = 1'b0;  bus_a.id_use_rs2 = 1'b0;
    bus_a.ex_rd = 5'd0;  bus_a.ex_mem_read = 1'b0;  bus_a.ex_redirect = 1'b0;
    bus_a.mem_req = 1'b0;  bus_a.mem_ready = 1'b0;
    bus_a.dbg_halt = 1'b0;  bus_a.dbg_step = 1'b0;
    bus_b.id_rs1 = 5'd0;  bus_b.id_rs2 = 5'd0;
    bus_b.id_use_rs1 = 1'b0;  bus_b.id_use_rs2 = 1'b0;
    bus_b.ex_rd = 5'd0;  bus_b.ex_mem_read = 1'b0;  bus_b.ex_redirect = 1'b0;
    bus_b.mem_req = 1'b0;  bus_b.mem_ready = 1'b0;
    bus_b.dbg_halt = 1'b0;  bus_b.dbg_step = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    bus_a.ex_mem_read = 1'b1;
    bus_a.ex_rd       = rd;
    bus_a.id_rs1      = rd;
    bus_a.id_use_rs1  = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    #1 rst = 1'b1;
    // Hazard inputs active during reset must not leak through.
    set_lu(5'd5);
    bus_a.mem_req = 1'b1;
    #2;
    check("rst_ctrl",   32'(ca), 32'(C_NONE));
    check("rst_halted", 32'(bus_a.halted), 32'd0);
    check("rst_stall",  bus_a.stall_cnt, 32'd0);
    check("rst_flush",  bus_a.flush_cnt, 32'd0);
    check("rst_memerr", 32'(bus_a.mem_err), 32'd0);
    cyc();
    clr();
    @(negedge clk) rst = 1'b0;
    cyc();

    // Load-use on rs1.
    set_lu(5'd5);
    @(negedge clk) check("lu_rs1_ctrl", 32'(ca), 32'(C_LU));
    cyc();
    check("lu_rs1_cnt", bus_a.stall_cnt, 32'd1);
    // Same pattern against x0.
    set_lu(5'd0);
    @(negedge clk) check("lu_x0_ctrl", 32'(ca), 32'(C_NONE));
    cyc();
    check("lu_x0_cnt", bus_a.stall_cnt, 32'd1);
    // Load-use on rs2, rs1 matches but is unused.
    clr();
    bus_a.ex_mem_read = 1'b1; bus_a.ex_rd = 5'd7; bus_a.id_rs1 = 5'd7;
    bus_a.id_rs2 = 5'd7; bus_a.id_use_rs2 = 1'b1;
    @(negedge clk) check("lu_rs2_ctrl", 32'(ca), 32'(C_LU));
    cyc();
    check("lu_rs2_cnt", bus_a.stall_cnt, 32'd2);
    bus_a.id_use_rs2 = 1'b0;
    @(negedge clk) check("lu_unused_ctrl", 32'(ca), 32'(C_NONE));
    cyc();

    // Redirect overrides load-use.
    clr();
    set_lu(5'd5);
    bus_a.ex_redirect = 1'b1;
    @(negedge clk) check("redir_ctrl", 32'(ca), 32'(C_REDIR));
    cyc();
    check("redir_flush", bus_a.flush_cnt, 32'd1);
    check("redir_stall", bus_a.stall_cnt, 32'd2);

    // Three wait cycles with a redirect that must be ignored, then ready.
    clr();
    bus_a.mem_req = 1'b1; bus_a.ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) check("mw_ctrl", 32'(ca), 32'(C_FREEZE));
      cyc();
      check("mw_state", 32'(dut_a.state_q), 32'(ST_MEMWAIT));
    end
    check("mw_flush_hold", bus_a.flush_cnt, 32'd1);
    bus_a.mem_ready = 1'b1;
    @(negedge clk) check("mw_ready_ctrl", 32'(ca), 32'(C_REDIR));
    cyc();
    check("mw_ready_state", 32'(dut_a.state_q), 32'(ST_RUN));
    check("mw_stall", bus_a.stall_cnt, 32'd5);
    check("mw_flush", bus_a.flush_cnt, 32'd2);

    // Timeout: first wait cycle is in RUN, increments begin in MEMWAIT.
    clr();
    bus_a.mem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) check("to_ctrl", 32'(ca), 32'(C_FREEZE));
      cyc();
      if (i == 3) check("to_err_early", 32'(bus_a.mem_err), 32'd0);
      if (i == 4) check("to_err_set", 32'(bus_a.mem_err), 32'd1);
    end
    bus_a.mem_ready = 1'b1;
    cyc();
    check("to_state", 32'(dut_a.state_q), 32'(ST_RUN));
    clr();
    cyc(); cyc();
    check("to_err_sticky", 32'(bus_a.mem_err), 32'd1);
    check("to_stall", bus_a.stall_cnt, 32'd11);

    // Debug halt, held freeze, single step, resume.
    bus_a.dbg_halt = 1'b1;
    @(negedge clk) begin
      check("dh_entry_ctrl", 32'(ca), 32'(C_NONE));
      check("dh_entry_halted", 32'(bus_a.halted), 32'd0);
    end
    cyc();
    check("dh_halted", 32'(bus_a.halted), 32'd1);
    set_lu(5'd5);
    bus_a.ex_redirect = 1'b1;
    @(negedge clk) check("dh_freeze", 32'(ca), 32'(C_FREEZE));
    cyc();
    check("dh_stall_hold", bus_a.stall_cnt, 32'd11);
    check("dh_flush_hold", bus_a.flush_cnt, 32'd2);
    bus_a.ex_redirect = 1'b0; bus_a.ex_mem_read = 1'b0; bus_a.id_use_rs1 = 1'b0;
    bus_a.dbg_step = 1'b1;
    @(negedge clk) check("ds_req_freeze", 32'(ca), 32'(C_FREEZE));
    cyc();
    bus_a.dbg_step = 1'b0;
    set_lu(5'd5);
    @(negedge clk) begin
      check("ds_step_ctrl", 32'(ca), 32'(C_LU));
      check("ds_step_halted", 32'(bus_a.halted), 32'd0);
    end
    cyc();
    check("ds_rehalt", 32'(bus_a.halted), 32'd1);
    check("ds_stall", bus_a.stall_cnt, 32'd12);
    bus_a.ex_mem_read = 1'b0; bus_a.id_use_rs1 = 1'b0;
    bus_a.dbg_halt = 1'b0;
    cyc();
    @(negedge clk) begin
      check("dr_halted", 32'(bus_a.halted), 32'd0);
      check("dr_ctrl", 32'(ca), 32'(C_NONE));
    end

    // dbg_step in RUN is ignored.
    bus_a.dbg_step = 1'b1;
    cyc();
    bus_a.dbg_step = 1'b0;
    check("step_run_state", 32'(dut_a.state_q), 32'(ST_RUN));

    // Halt and memwait together: memwait first, HALT after ready.
    bus_a.dbg_halt = 1'b1; bus_a.mem_req = 1'b1;
    @(negedge clk) check("hm_ctrl", 32'(ca), 32'(C_FREEZE));
    cyc();
    check("hm_state", 32'(dut_a.state_q), 32'(ST_MEMWAIT));
    bus_a.mem_ready = 1'b1;
    @(negedge clk) check("hm_ready_ctrl", 32'(ca), 32'(C_NONE));
    cyc();
    check("hm_halted", 32'(bus_a.halted), 32'd1);
    check("hm_stall", bus_a.stall_cnt, 32'd13);
    clr();
    cyc();
    check("hm_resume", 32'(bus_a.halted), 32'd0);

    // Step cycle hits memwait: returns to HALT even with dbg_halt dropped.
    bus_a.dbg_halt = 1'b1;
    cyc();
    bus_a.dbg_step = 1'b1;
    cyc();
    check("sm_state_step", 32'(dut_a.state_q), 32'(ST_STEP));
    bus_a.dbg_step = 1'b0; bus_a.dbg_halt = 1'b0; bus_a.mem_req = 1'b1;
    @(negedge clk) check("sm_ctrl", 32'(ca), 32'(C_FREEZE));
    cyc();
    check("sm_state_mw", 32'(dut_a.state_q), 32'(ST_MEMWAIT));
    bus_a.mem_ready = 1'b1;
    cyc();
    check("sm_ret_halt", 32'(bus_a.halted), 32'd1);
    check("sm_stall", bus_a.stall_cnt, 32'd14);
    clr();
    cyc();
    check("sm_resume", 32'(dut_a.state_q), 32'(ST_RUN));

    // Asynchronous reset in the middle of a wait.
    bus_a.mem_req = 1'b1;
    cyc(); cyc();
    check("ar_pre_state", 32'(dut_a.state_q), 32'(ST_MEMWAIT));
    #2 rst = 1'b1;
    #1;
    check("ar_ctrl",   32'(ca), 32'(C_NONE));
    check("ar_state",  32'(dut_a.state_q), 32'(ST_RUN));
    check("ar_stall",  bus_a.stall_cnt, 32'd0);
    check("ar_flush",  bus_a.flush_cnt, 32'd0);
    check("ar_memerr", 32'(bus_a.mem_err), 32'd0);
    clr();
    @(negedge clk) rst = 1'b0;
    cyc();

    // Saturation on the 3-bit instance.
    bus_b.ex_mem_read = 1'b1; bus_b.ex_rd = 5'd3; bus_b.id_rs1 = 5'd3; bus_b.id_use_rs1 = 1'b1;
    for (int i = 0; i < 9; i++) cyc();
    check("sat_stall", 32'(bus_b.stall_cnt), 32'd7);
    clr();
    bus_b.ex_redirect = 1'b1;
    for (int i = 0; i < 9; i++) cyc();
    check("sat_flush", 32'(bus_b.flush_cnt), 32'd7);
    check("sat_stall_hold", 32'(bus_b.stall_cnt), 32'd7);
    clr();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives hold/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Arbitrates four event sources: data-memory wait, taken branch/jump resolved in EX, load-use hazard, and debug halt/single-step.
- Also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_W, 32, width of the performance counters.
- MEM_TIMEOUT, 255, consecutive mem-wait cycles before mem_err is set.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle
- mem_req  in  1  MEM stage accesses data memory this cycle
- mem_ready  in  1  data memory completes the access this cycle
- dbg_halt  in  1  level; request pipeline freeze
- dbg_step  in  1  pulse; advance one cycle while halted
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID (LoadStall)
- ifid_flush  out  1  bubble IF/ID (BranchStall)
- idex_stall  out  1  hold ID/EX
- idex_flush  out  1  bubble ID/EX
- exmem_stall  out  1  hold EX/MEM
- memwb_flush  out  1  bubble MEM/WB
- halted  out  1  state is HALT
- mem_err  out  1  sticky memory timeout
- stall_cnt  out  CNT_W  cycles with pc_stall=1 outside HALT
- flush_cnt  out  CNT_W  number of redirect flushes

Behaviour:
- rst is asynchronous, active-high; clk is the clock.
- While rst=1:
  - state=RUN, ret_halt=0, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
  - All stall/flush outputs forced 0; halted=0.
- States: RUN, HALT, STEP, MEMWAIT. Controls are Mealy (same cycle as the inputs); no added latency.
- Hazard terms:
  - memwait = mem_req & ~mem_ready.
  - loaduse = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Freeze set: pc_stall, ifid_stall, idex_stall and exmem_stall =1, memwb_flush=1, all other outputs 0.
- Priority in RUN, STEP and MEMWAIT:
  1. memwait: freeze set. ex_redirect and loaduse are ignored; they are re-evaluated next cycle because stages hold.
  2. ex_redirect: ifid_flush=1, idex_flush=1, everything else 0. flush_cnt+1. Overrides loaduse, since the ID instruction is wrong-path.
  3. loaduse: pc_stall=1, ifid_stall=1, idex_flush=1.
  4. Otherwise all controls are 0.
- HALT: freeze set every cycle regardless of other inputs; halted=1; counters hold.
- Transitions:
  - RUN:
    - memwait -> MEMWAIT with ret_halt=0.
    - else dbg_halt -> HALT. The current cycle still advances normally.
  - HALT:
    - dbg_step -> STEP.
    - else if ~dbg_halt -> RUN.
  - STEP: the single cycle is evaluated with RUN priority.
    - memwait -> MEMWAIT with ret_halt=1.
    - else -> HALT if dbg_halt, else RUN.
  - MEMWAIT:
    - While memwait: stay, and wait_cnt+1 saturating.
    - When wait_cnt reaches MEM_TIMEOUT, mem_err:=1. mem_err is cleared only by rst.
    - When ~memwait (the ready cycle): priority items 2–4 apply, wait_cnt:=0, and next state = (ret_halt | dbg_halt) ? HALT : RUN.
- Counters:
  - stall_cnt increments in any non-HALT cycle with pc_stall=1.
  - Both counters saturate at all-ones and never wrap.
- Simultaneous events:
  - dbg_step in RUN is ignored.
  - dbg_halt and memwait in the same RUN cycle: memwait wins; HALT is entered after MEMWAIT completes.
- Reset mid-MEMWAIT or mid-HALT returns to RUN immediately and asynchronously.

Decomposition:
- Shared header (alongside the existing macro header):
  - State encodings ST_RUN=2'd0, ST_HALT=2'd1, ST_STEP=2'd2, ST_MEMWAIT=2'd3.
  - Register x0 constant.
- One combinational sub-module, hazard_detect: computes loaduse and the prioritized flush/stall vector from the hazard inputs.
- pipe_hazard_ctrl holds the FSM, the freeze override and the counters.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_stall=ifid_stall=idex_flush=1 that cycle; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Redirect vs load-use: ex_redirect=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_stall=0; flush_cnt=1.
- Mem wait: mem_req=1, mem_ready=0 for 3 cycles then ready=1 -> freeze set for 3 cycles; state MEMWAIT then RUN; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_ready=0 for 6 cycles -> mem_err=1 after the 4th wait-count increment; it stays 1 after ready, until rst.
- Debug: assert dbg_halt -> halted=1 next cycle, freeze held. A dbg_step pulse -> exactly one non-frozen cycle, then halted=1. Drop dbg_halt -> RUN.
- Async reset during MEMWAIT with counters nonzero -> all outputs 0 immediately; state RUN; counters 0.
